// File: rtl/pm_write_sched.sv
// rtl/pm_write_sched.sv - ACS write scheduler for the Viterbi path-metric register stage
module pm_write_sched #(
    parameter int PM_W     = 7,
    parameter int NSTATE   = 4,
    parameter int MAX_OUT  = 4,
    parameter int NORM_TH  = 64,
    parameter int NORM_SUB = 64,
    localparam int AW      = $clog2(NSTATE)
) (
    input  logic            PM_clk,
    input  logic            PM_rst,
    input  logic            acs0_valid,
    output logic            acs0_ready,
    input  logic [PM_W-1:0] acs0_pm,
    input  logic [AW-1:0]   acs0_addr,
    input  logic            acs0_dec,
    input  logic            acs1_valid,
    output logic            acs1_ready,
    input  logic [PM_W-1:0] acs1_pm,
    input  logic [AW-1:0]   acs1_addr,
    input  logic            acs1_dec,
    input  logic            tb_ack,
    output logic [PM_W-1:0] pm_out,
    output logic [AW-1:0]   addr_out,
    output logic            dec_out,
    output logic            data_en,
    output logic [2:0]      data_id,
    output logic            sym_done,
    output logic [2:0]      sym_id,
    output logic            norm_active,
    output logic            dup_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_CLOSE,
        S_STALL
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [NSTATE-1:0]   r_mask;
    logic [PM_W-1:0]     r_min_pm;
    logic [2:0]          r_id;
    logic [3:0]          r_out;
    logic                r_last;
    logic                r_norm_active;
    logic [PM_W-1:0]     r_pm_out;
    logic [AW-1:0]       r_addr_out;
    logic                r_dec_out;
    logic                r_data_en;
    logic [2:0]          r_data_id;
    logic                r_dup_err;

    logic                w_open;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_xfer;
    logic                w_dup;
    logic                w_wr;
    logic [PM_W-1:0]     w_pm_sel;
    logic [AW-1:0]       w_addr_sel;
    logic                w_dec_sel;
    logic [NSTATE-1:0]   w_mask_set;
    logic [PM_W:0]       w_diff;
    logic [PM_W-1:0]     w_pm_norm;
    logic [3:0]          w_out_nxt;

    // Grants are only possible while collecting; reset also forces readies low.
    assign w_open = PM_rst && ((r_state == S_IDLE) || (r_state == S_COLLECT));

    // Round-robin grant: a lone requester wins, contention goes to the one not served last.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_open) begin
            if (acs0_valid && acs1_valid) begin
                if (r_last) w_gnt0 = 1'b1;
                else        w_gnt1 = 1'b1;
            end else if (acs0_valid) begin
                w_gnt0 = 1'b1;
            end else if (acs1_valid) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign acs0_ready = w_gnt0;
    assign acs1_ready = w_gnt1;
    assign w_xfer     = w_gnt0 | w_gnt1;

    assign w_pm_sel   = w_gnt1 ? acs1_pm   : acs0_pm;
    assign w_addr_sel = w_gnt1 ? acs1_addr : acs0_addr;
    assign w_dec_sel  = w_gnt1 ? acs1_dec  : acs0_dec;

    // A repeated state index is accepted but never reaches the register stage.
    assign w_dup      = r_mask[w_addr_sel];
    assign w_wr       = w_xfer & ~w_dup;
    assign w_mask_set = r_mask | (NSTATE'(1) << w_addr_sel);

    // Normalisation works one bit wider so an underflow shows up as the sign bit.
    assign w_diff     = {1'b0, w_pm_sel} - (PM_W + 1)'(NORM_SUB);
    assign w_pm_norm  = r_norm_active ? (w_diff[PM_W] ? '0 : w_diff[PM_W-1:0]) : w_pm_sel;

    // Outstanding symbols: a close adds one, an ack in the same cycle cancels it.
    always_comb begin
        w_out_nxt = r_out;
        if (r_state == S_CLOSE) begin
            if (!tb_ack) w_out_nxt = r_out + 4'd1;
        end else if (tb_ack && (r_out != 4'd0)) begin
            w_out_nxt = r_out - 4'd1;
        end
    end

    // Symbol state register.
    always_ff @(posedge PM_clk or negedge PM_rst) begin
        if (!PM_rst) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic: collect until every state is written, close for one cycle, stall on credits.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_COLLECT: begin
                if (w_wr && (&w_mask_set)) w_state_nxt = S_CLOSE;
                else if (w_xfer)           w_state_nxt = S_COLLECT;
            end
            S_CLOSE: begin
                if (w_out_nxt == 4'(MAX_OUT)) w_state_nxt = S_STALL;
                else                          w_state_nxt = S_IDLE;
            end
            S_STALL: begin
                if (tb_ack) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Write pipeline, per-symbol bookkeeping and credit counter.
    always_ff @(posedge PM_clk or negedge PM_rst) begin
        if (!PM_rst) begin
            r_mask        <= '0;
            r_min_pm      <= '1;
            r_id          <= 3'd0;
            r_out         <= 4'd0;
            r_last        <= 1'b1;
            r_norm_active <= 1'b0;
            r_pm_out      <= '0;
            r_addr_out    <= '0;
            r_dec_out     <= 1'b0;
            r_data_en     <= 1'b0;
            r_data_id     <= 3'd0;
            r_dup_err     <= 1'b0;
        end else begin
            r_data_en <= w_wr;
            r_dup_err <= w_xfer & w_dup;
            r_out     <= w_out_nxt;
            if (w_xfer) r_last <= w_gnt1;
            if (w_wr) begin
                r_pm_out   <= w_pm_norm;
                r_addr_out <= w_addr_sel;
                r_dec_out  <= w_dec_sel;
                r_data_id  <= r_id;
                r_mask     <= w_mask_set;
                if (w_pm_norm < r_min_pm) r_min_pm <= w_pm_norm;
            end
            if (r_state == S_CLOSE) begin
                r_id          <= r_id + 3'd1;
                r_norm_active <= ({1'b0, r_min_pm} >= (PM_W + 1)'(NORM_TH));
                r_min_pm      <= '1;
                r_mask        <= '0;
            end
        end
    end

    assign pm_out      = r_pm_out;
    assign addr_out    = r_addr_out;
    assign dec_out     = r_dec_out;
    assign data_en     = r_data_en;
    assign data_id     = r_data_id;
    assign dup_err     = r_dup_err;
    assign norm_active = r_norm_active;
    assign sym_done    = (r_state == S_CLOSE);
    assign sym_id      = (r_state == S_CLOSE) ? r_id : 3'd0;

endmodule

// File: tb/tb_pm_write_sched.sv
// tb/tb_pm_write_sched.sv - directed self-checking bench for pm_write_sched
module tb_pm_write_sched;

    logic       PM_clk = 1'b0;
    logic       PM_rst = 1'b0;
    logic       acs0_valid = 1'b0, acs1_valid = 1'b0;
    logic       acs0_ready, acs1_ready;
    logic [6:0] acs0_pm = '0, acs1_pm = '0;
    logic [1:0] acs0_addr = '0, acs1_addr = '0;
    logic       acs0_dec = 1'b0, acs1_dec = 1'b0;
    logic       tb_ack = 1'b0;
    logic [6:0] pm_out;
    logic [1:0] addr_out;
    logic       dec_out, data_en, sym_done, norm_active, dup_err;
    logic [2:0] data_id, sym_id;

    int total = 0;
    int bad   = 0;

    pm_write_sched dut (
        .PM_clk(PM_clk), .PM_rst(PM_rst),
        .acs0_valid(acs0_valid), .acs0_ready(acs0_ready), .acs0_pm(acs0_pm),
        .acs0_addr(acs0_addr), .acs0_dec(acs0_dec),
        .acs1_valid(acs1_valid), .acs1_ready(acs1_ready), .acs1_pm(acs1_pm),
        .acs1_addr(acs1_addr), .acs1_dec(acs1_dec),
        .tb_ack(tb_ack), .pm_out(pm_out), .addr_out(addr_out), .dec_out(dec_out),
        .data_en(data_en), .data_id(data_id), .sym_done(sym_done), .sym_id(sym_id),
        .norm_active(norm_active), .dup_err(dup_err)
    );

    always #5 PM_clk = ~PM_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PM_clk);
        #1;
    endtask

    task automatic do_reset();
        acs0_valid = 1'b0;
        acs1_valid = 1'b0;
        tb_ack     = 1'b0;
        @(negedge PM_clk);
        PM_rst = 1'b0;
        @(negedge PM_clk);
        PM_rst = 1'b1;
    endtask

    task automatic wr(input int port, input logic [1:0] a, input logic [6:0] pm, input logic d,
                      input logic [6:0] exp_pm, input logic [2:0] exp_id, input string tag);
        if (port == 0) begin
            acs0_valid = 1'b1; acs0_addr = a; acs0_pm = pm; acs0_dec = d; acs1_valid = 1'b0;
        end else begin
            acs1_valid = 1'b1; acs1_addr = a; acs1_pm = pm; acs1_dec = d; acs0_valid = 1'b0;
        end
        #1;
        chk({tag, "_rdy"}, (port == 0) ? acs0_ready : acs1_ready, 1);
        tick();
        acs0_valid = 1'b0;
        acs1_valid = 1'b0;
        chk({tag, "_en"},   data_en,  1);
        chk({tag, "_pm"},   pm_out,   exp_pm);
        chk({tag, "_addr"}, addr_out, a);
        chk({tag, "_dec"},  dec_out,  d);
        chk({tag, "_id"},   data_id,  exp_id);
    endtask

    task automatic sym(input logic [2:0] id);
        for (int a = 0; a < 4; a++) wr(0, 2'(a), 7'd10, 1'b0, 7'd10, id, "t6_wr");
        chk("t6_done", sym_done, 1);
        chk("t6_sid",  sym_id,   id);
        tick();
    endtask

    initial begin
        // T1: outputs and readies held at zero in reset, including a mid-symbol reset
        acs0_valid = 1'b1;
        acs1_valid = 1'b1;
        #2;
        chk("t1_rdy0", acs0_ready, 0);
        chk("t1_rdy1", acs1_ready, 0);
        chk("t1_en",   data_en,    0);
        chk("t1_done", sym_done,   0);
        acs0_valid = 1'b0;
        acs1_valid = 1'b0;
        @(negedge PM_clk);
        PM_rst = 1'b1;
        wr(0, 2'd0, 7'd33, 1'b1, 7'd33, 3'd0, "t1_w0");
        wr(0, 2'd1, 7'd34, 1'b0, 7'd34, 3'd0, "t1_w1");
        acs0_valid = 1'b1;
        PM_rst     = 1'b0;
        #1;
        chk("t1m_rdy0", acs0_ready, 0);
        chk("t1m_en",   data_en,    0);
        chk("t1m_pm",   pm_out,     0);
        chk("t1m_addr", addr_out,   0);
        chk("t1m_id",   data_id,    0);
        chk("t1m_norm", norm_active, 0);
        chk("t1m_dup",  dup_err,    0);
        acs0_valid = 1'b0;
        @(negedge PM_clk);
        PM_rst = 1'b1;

        // T2: single requester, four consecutive writes, then the next symbol id
        wr(0, 2'd0, 7'd10, 1'b0, 7'd10, 3'd0, "t2_w0");
        chk("t2_nd0", sym_done, 0);
        wr(0, 2'd1, 7'd20, 1'b1, 7'd20, 3'd0, "t2_w1");
        wr(0, 2'd2, 7'd30, 1'b0, 7'd30, 3'd0, "t2_w2");
        chk("t2_nd2", sym_done, 0);
        wr(0, 2'd3, 7'd40, 1'b1, 7'd40, 3'd0, "t2_w3");
        chk("t2_done", sym_done, 1);
        chk("t2_sid",  sym_id,   0);
        acs0_valid = 1'b1; acs0_addr = 2'd0; acs0_pm = 7'd15;
        #1;
        chk("t2_close_rdy", acs0_ready, 0);
        tick();
        chk("t2_idle_en",   data_en,  0);
        chk("t2_idle_done", sym_done, 0);
        wr(0, 2'd0, 7'd15, 1'b0, 7'd15, 3'd1, "t2_next");

        // T3: round-robin between two always-valid requesters
        do_reset();
        acs0_valid = 1'b1; acs0_addr = 2'd0; acs0_pm = 7'd11;
        acs1_valid = 1'b1; acs1_addr = 2'd2; acs1_pm = 7'd22;
        #1;
        chk("t3_g1_r0", acs0_ready, 1);
        chk("t3_g1_r1", acs1_ready, 0);
        tick();
        chk("t3_g1_addr", addr_out, 0);
        chk("t3_g1_pm",   pm_out,   11);
        acs0_addr = 2'd1; acs0_pm = 7'd12;
        #1;
        chk("t3_g2_r0", acs0_ready, 0);
        chk("t3_g2_r1", acs1_ready, 1);
        tick();
        chk("t3_g2_en",   data_en,  1);
        chk("t3_g2_addr", addr_out, 2);
        acs1_addr = 2'd3; acs1_pm = 7'd23;
        #1;
        chk("t3_g3_r0", acs0_ready, 1);
        chk("t3_g3_r1", acs1_ready, 0);
        tick();
        chk("t3_g3_en",   data_en,  1);
        chk("t3_g3_addr", addr_out, 1);
        chk("t3_g4_r0", acs0_ready, 0);
        chk("t3_g4_r1", acs1_ready, 1);
        tick();
        chk("t3_g4_en",   data_en,  1);
        chk("t3_g4_addr", addr_out, 3);
        chk("t3_g4_pm",   pm_out,   23);
        chk("t3_done",    sym_done, 1);
        acs0_valid = 1'b0;
        acs1_valid = 1'b0;

        // T4: duplicate state write is accepted and dropped
        do_reset();
        wr(0, 2'd0, 7'd40, 1'b0, 7'd40, 3'd0, "t4_w0");
        acs0_valid = 1'b1; acs0_addr = 2'd0; acs0_pm = 7'd1;
        #1;
        chk("t4_dup_rdy", acs0_ready, 1);
        tick();
        acs0_valid = 1'b0;
        chk("t4_dup_en",  data_en, 0);
        chk("t4_dup_err", dup_err, 1);
        wr(1, 2'd1, 7'd41, 1'b1, 7'd41, 3'd0, "t4_w1");
        chk("t4_dup_clr", dup_err, 0);
        wr(0, 2'd2, 7'd42, 1'b0, 7'd42, 3'd0, "t4_w2");
        chk("t4_nd2", sym_done, 0);
        wr(0, 2'd3, 7'd43, 1'b0, 7'd43, 3'd0, "t4_w3");
        chk("t4_done", sym_done, 1);

        // T5: normalisation armed by a high minimum, saturating at zero
        do_reset();
        wr(0, 2'd0, 7'd70,  1'b0, 7'd70,  3'd0, "t5_a0");
        wr(0, 2'd1, 7'd80,  1'b0, 7'd80,  3'd0, "t5_a1");
        wr(0, 2'd2, 7'd90,  1'b0, 7'd90,  3'd0, "t5_a2");
        wr(0, 2'd3, 7'd100, 1'b0, 7'd100, 3'd0, "t5_a3");
        chk("t5_norm_close", norm_active, 0);
        tick();
        chk("t5_norm_on", norm_active, 1);
        wr(0, 2'd0, 7'd66,  1'b0, 7'd2,  3'd1, "t5_b0");
        wr(0, 2'd1, 7'd64,  1'b0, 7'd0,  3'd1, "t5_b1");
        wr(0, 2'd2, 7'd50,  1'b0, 7'd0,  3'd1, "t5_b2");
        wr(0, 2'd3, 7'd127, 1'b0, 7'd63, 3'd1, "t5_b3");
        chk("t5_sid", sym_id, 1);
        tick();
        chk("t5_norm_off", norm_active, 0);

        // T6: traceback credits throttle issue
        do_reset();
        sym(3'd0);
        sym(3'd1);
        sym(3'd2);
        sym(3'd3);
        acs0_valid = 1'b1; acs0_addr = 2'd0; acs0_pm = 7'd10; acs0_dec = 1'b0;
        #1;
        chk("t6_stall_rdy", acs0_ready, 0);
        tick();
        chk("t6_stall_en",   data_en,    0);
        chk("t6_stall_rdy2", acs0_ready, 0);
        tb_ack = 1'b1;
        tick();
        tb_ack = 1'b0;
        chk("t6_resume_rdy", acs0_ready, 1);
        tick();
        acs0_valid = 1'b0;
        chk("t6_resume_en", data_en, 1);
        chk("t6_resume_id", data_id, 4);
        wr(0, 2'd1, 7'd10, 1'b0, 7'd10, 3'd4, "t6_s4");
        wr(0, 2'd2, 7'd10, 1'b0, 7'd10, 3'd4, "t6_s4");
        wr(0, 2'd3, 7'd10, 1'b0, 7'd10, 3'd4, "t6_s4");
        chk("t6_s4_sid", sym_id, 4);
        tb_ack = 1'b1;
        tick();
        tb_ack = 1'b0;
        acs0_valid = 1'b1; acs0_addr = 2'd0;
        #1;
        chk("t6_ackclose_rdy", acs0_ready, 1);
        acs0_valid = 1'b0;
        sym(3'd5);
        acs0_valid = 1'b1; acs0_addr = 2'd0;
        #1;
        chk("t6_restall_rdy", acs0_ready, 0);
        acs0_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
